uart_emitter_arbiter: RTL and testbench
=======================================

Name: uart_emitter_arbiter

Overview:
Shares one byte-serial UART emitter between NUM_REQ independent requesters (trace, status and debug byte streams). It grants the emitter round-robin and holds each grant for a whole message, delimited by a last flag. Sits directly upstream of the UART emitter's valid/ready byte input.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
MAX_BURST, 0, max bytes per grant before forced release; 0 = unlimited.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_req_data  input  8*NUM_REQ  per-requester byte; requester r uses bits [8r+7:8r]
i_req_valid  input  NUM_REQ  per-requester byte valid
i_req_last  input  NUM_REQ  byte is the final byte of the message
o_req_ready  output  NUM_REQ  per-requester byte accepted
o_data  output  8  byte to emitter
o_valid  output  1  byte valid to emitter
i_ready  input  1  emitter ready
o_grant  output  $clog2(NUM_REQ)  index of current owner
o_busy  output  1  a grant is held

Behaviour:
- Clock and reset: one clock i_clk; i_rst_n is synchronous, active-low.
- Reset values: state=IDLE, o_grant=0, RR pointer=0, burst count=0, o_busy=0. Combinationally this gives o_valid=0 and o_req_ready=0.
- Transfer: a byte transfers on a cycle where o_valid & i_ready.
- States: IDLE, TAG (optional feature only), PASS.
- IDLE:
  - o_valid=0, all o_req_ready=0.
  - If any i_req_valid, pick the first valid index at or after ptr, wrapping modulo NUM_REQ.
  - Register it into o_grant, set o_busy=1, clear burst count, go to PASS (or TAG).
  - One arbitration cycle between messages.
- PASS:
  - o_data = i_req_data[g].
  - o_valid = i_req_valid[g].
  - o_req_ready[g] = i_ready; all other ready bits are 0. Combinational passthrough, zero added latency.
  - On transfer, increment burst count.
  - Release on transfer with i_req_last[g], or when the incremented count == MAX_BURST (MAX_BURST>0).
  - Release means: go to IDLE, o_busy=0, ptr=(g+1) mod NUM_REQ.
- Owner drops valid mid-message: grant is held indefinitely; no timeout, no switching.
- Last on the first byte: single-byte message, released after one transfer.
- Simultaneous transfer with last and count==MAX_BURST: one release, ptr advances once.
- Requests arriving while busy wait; they are not lost. After a release, the owner has lowest priority.
- Burst counter width is $clog2(MAX_BURST+1). It is absent when MAX_BURST=0.
- i_req_data of non-granted requesters is ignored.
- Reset mid-message: next edge forces IDLE and drops all readys. Bytes already accepted by the emitter complete on the line. The interrupted requester must restart its message.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined:
  - After arbitration the FSM enters TAG.
  - TAG drives o_valid=1 and o_data = 8'h41 + g ('A','B',...), with all o_req_ready=0.
  - On i_ready, go to PASS.
  - The tag byte does not count toward MAX_BURST.
  - Reset in TAG returns to IDLE.
- Undefined: TAG state and its logic are absent; IDLE goes straight to PASS.

Test Plan:
- Single requester: r1 sends 0x55,0xAA(last), i_ready=1 -> o_data 0x55 then 0xAA on consecutive cycles. o_grant=1, o_busy drops the cycle after 0xAA, ptr=2.
- Contention: r0 and r2 each send a 2-byte message simultaneously from reset -> r0's bytes first, one IDLE cycle, then r2's. No interleaving.
- Fairness: all 4 requesters continuously send 1-byte messages -> grant order 0,1,2,3,0,1.
- Backpressure and stall: i_ready toggles 1/0 and the owner deasserts valid for 3 cycles mid-message -> no bytes lost or duplicated; grant held; o_req_ready only on the owner.
- Burst cap: MAX_BURST=3, r0 sends 5 bytes with last on the 5th and r1 is pending -> 3 bytes from r0, then r1's message, then r0's remaining 2.
- Reset and tag: i_rst_n=0 after the 2nd of 4 bytes -> next cycle o_valid=0, o_busy=0, o_grant=0. With UART_ARB_TAG_EN, r2's message is preceded by 0x43.

Source files
------------

// File: rtl/uart_emitter_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART byte emitter.
// Optional tag byte before each message: define UART_ARB_TAG_EN.
module uart_emitter_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [7:0]                 o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_busy
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
`ifdef UART_ARB_TAG_EN
  localparam logic [1:0] TAG  = 2'd2;
`endif

  logic [1:0]    state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] pick;
  logic [GW-1:0] nxt;
  logic          found;
  logic          xfer;
  logic          cap_hit;
  logic          rel;
  int            idx;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign nxt  = (o_grant == GW'(NUM_REQ - 1)) ? '0 : o_grant + GW'(1);
  assign xfer = (state == PASS) && o_valid && i_ready;
  assign rel  = xfer && (i_req_last[o_grant] || cap_hit);

  generate
    if (MAX_BURST > 0) begin : g_burst
      localparam int BW = $clog2(MAX_BURST + 1);
      logic [BW-1:0] cnt;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n)
          cnt <= '0;
        else if (state == IDLE)
          cnt <= '0;
        else if (xfer)
          cnt <= cnt + BW'(1);
      end
      assign cap_hit = (cnt == BW'(MAX_BURST - 1));
    end else begin : g_noburst
      assign cap_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_grant <= '0;
      ptr     <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            o_grant <= pick;
            o_busy  <= 1'b1;
`ifdef UART_ARB_TAG_EN
            state   <= TAG;
`else
            state   <= PASS;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          if (i_ready)
            state <= PASS;
        end
`endif
        PASS: begin
          if (rel) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            ptr    <= nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency passthrough from the owner to the emitter.
  always_comb begin
    o_valid     = 1'b0;
    o_data      = 8'h00;
    o_req_ready = '0;
    if (state == PASS) begin
      o_data               = i_req_data[8*o_grant +: 8];
      o_valid              = i_req_valid[o_grant];
      o_req_ready[o_grant] = i_ready;
    end
`ifdef UART_ARB_TAG_EN
    if (state == TAG) begin
      o_valid = 1'b1;
      o_data  = 8'h41 + 8'(o_grant);
    end
`endif
  end

endmodule

// File: tb/tb_uart_emitter_arbiter.sv
// Directed bench for uart_emitter_arbiter (NUM_REQ=4, MAX_BURST=3).
// Expectations assume the default build without the tag byte.
module tb_uart_emitter_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  data;
  logic        valid;
  logic        ready = 1'b0;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_emitter_arbiter #(.NUM_REQ(4), .MAX_BURST(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_data (req_data),
    .i_req_valid(req_valid),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_grant    (grant),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [3:0]  er;
    logic [1:0]  eg;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic rdy,
                     input logic ev, input logic [7:0] ed,
                     input logic [3:0] er, input logic [1:0] eg,
                     input logic eb);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.er = er; t.eg = eg; t.eb = eb;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outputs", {valid, req_ready, grant, busy}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic rdy);
    @(posedge clk); #1;
    req_valid = v; req_last = l; req_data = d; ready = rdy;
    @(negedge clk);
  endtask

  logic [7:0] got[$];
  logic [7:0] exp_bytes[4];
  int sent0, sent2, multi;

  initial begin
    // Single requester, rotation from ptr=2, backpressure/stall,
    // burst cap with pending requester, last coinciding with cap.
    add(4'b0010, 4'b0000, 32'hEEEE55EE, 1, 0, 8'h00, 4'b0000, 2'd0, 0);
    add(4'b0010, 4'b0000, 32'hEEEE55EE, 1, 1, 8'h55, 4'b0010, 2'd1, 1);
    add(4'b0010, 4'b0010, 32'hEEEEAAEE, 1, 1, 8'hAA, 4'b0010, 2'd1, 1);
    add(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd1, 0);
    add(4'b1010, 4'b1010, 32'h33001100, 1, 0, 8'h00, 4'b0000, 2'd1, 0);
    add(4'b1010, 4'b1010, 32'h33001100, 1, 1, 8'h33, 4'b1000, 2'd3, 1);
    add(4'b1010, 4'b1010, 32'h33001100, 1, 0, 8'h00, 4'b0000, 2'd3, 0);
    add(4'b1010, 4'b1010, 32'h33001100, 1, 1, 8'h11, 4'b0010, 2'd1, 1);
    add(4'b0001, 4'b0000, 32'h000000A0, 0, 0, 8'h00, 4'b0000, 2'd1, 0);
    add(4'b0001, 4'b0000, 32'h000000A0, 0, 1, 8'hA0, 4'b0000, 2'd0, 1);
    add(4'b0001, 4'b0000, 32'h000000A0, 1, 1, 8'hA0, 4'b0001, 2'd0, 1);
    add(4'b0100, 4'b0000, 32'h00C000A1, 1, 0, 8'hA1, 4'b0001, 2'd0, 1);
    add(4'b0100, 4'b0000, 32'h00C000A1, 1, 0, 8'hA1, 4'b0001, 2'd0, 1);
    add(4'b0100, 4'b0000, 32'h00C000A1, 1, 0, 8'hA1, 4'b0001, 2'd0, 1);
    add(4'b0101, 4'b0001, 32'h00C000A1, 0, 1, 8'hA1, 4'b0000, 2'd0, 1);
    add(4'b0101, 4'b0001, 32'h00C000A1, 1, 1, 8'hA1, 4'b0001, 2'd0, 1);
    add(4'b0100, 4'b0100, 32'h00C00000, 1, 0, 8'h00, 4'b0000, 2'd0, 0);
    add(4'b0100, 4'b0100, 32'h00C00000, 1, 1, 8'hC0, 4'b0100, 2'd2, 1);
    add(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd2, 0);
    add(4'b0011, 4'b0010, 32'h0000C1B1, 1, 0, 8'h00, 4'b0000, 2'd2, 0);
    add(4'b0011, 4'b0010, 32'h0000C1B1, 1, 1, 8'hB1, 4'b0001, 2'd0, 1);
    add(4'b0011, 4'b0010, 32'h0000C1B2, 1, 1, 8'hB2, 4'b0001, 2'd0, 1);
    add(4'b0011, 4'b0010, 32'h0000C1B3, 1, 1, 8'hB3, 4'b0001, 2'd0, 1);
    add(4'b0011, 4'b0010, 32'h0000C1B4, 1, 0, 8'h00, 4'b0000, 2'd0, 0);
    add(4'b0011, 4'b0010, 32'h0000C1B4, 1, 1, 8'hC1, 4'b0010, 2'd1, 1);
    add(4'b0001, 4'b0000, 32'h000000B4, 1, 0, 8'h00, 4'b0000, 2'd1, 0);
    add(4'b0001, 4'b0000, 32'h000000B4, 1, 1, 8'hB4, 4'b0001, 2'd0, 1);
    add(4'b0001, 4'b0001, 32'h000000B5, 1, 1, 8'hB5, 4'b0001, 2'd0, 1);
    add(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd0, 0);
    add(4'b0100, 4'b0000, 32'h00D10000, 1, 0, 8'h00, 4'b0000, 2'd0, 0);
    add(4'b0100, 4'b0000, 32'h00D10000, 1, 1, 8'hD1, 4'b0100, 2'd2, 1);
    add(4'b0100, 4'b0000, 32'h00D20000, 1, 1, 8'hD2, 4'b0100, 2'd2, 1);
    add(4'b0100, 4'b0100, 32'h00D30000, 1, 1, 8'hD3, 4'b0100, 2'd2, 1);
    add(4'b1001, 4'b1001, 32'hF00000E0, 1, 0, 8'h00, 4'b0000, 2'd2, 0);
    add(4'b1001, 4'b1001, 32'hF00000E0, 1, 1, 8'hF0, 4'b1000, 2'd3, 1);
    add(4'b1001, 4'b1001, 32'hF00000E0, 1, 0, 8'h00, 4'b0000, 2'd3, 0);
    add(4'b1001, 4'b1001, 32'hF00000E0, 1, 1, 8'hE0, 4'b0001, 2'd0, 1);
    add(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd0, 0);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rdy);
      chk($sformatf("row%0d", i),
          {16'h0, valid, data, req_ready, grant, busy},
          {16'h0, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].eg, tbl[i].eb});
    end

    // Contention from reset: r0 and r2, two bytes each, no interleave.
    do_reset();
    sent0 = 0; sent2 = 0; multi = 0;
    exp_bytes = '{8'h0A, 8'h0B, 8'h2A, 8'h2B};
    for (int c = 0; c < 20; c++) begin
      drive({1'b0, sent2 < 2, 1'b0, sent0 < 2},
            {1'b0, sent2 == 1, 1'b0, sent0 == 1},
            {8'h00, 8'h2A + 8'(sent2), 8'h00, 8'h0A + 8'(sent0)}, 1'b1);
      if ($countones(req_ready) > 1) multi++;
      if (valid && ready) got.push_back(data);
      if (req_ready[0] && req_valid[0]) sent0++;
      if (req_ready[2] && req_valid[2]) sent2++;
    end
    chk("contention_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("contention_byte%0d", i),
          (i < got.size()) ? got[i] : 8'hXX, exp_bytes[i]);
    chk("single_ready", multi, 0);

    // Fairness: all four send single-byte messages.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'hF, 4'hF, 32'h13121110, 1'b1);
      chk($sformatf("fair_idle%0d", k), {valid, busy}, 2'b00);
      drive(4'hF, 4'hF, 32'h13121110, 1'b1);
      chk($sformatf("fair_grant%0d", k), {valid, grant, data},
          {1'b1, 2'(k % 4), 8'h10 + 8'(k % 4)});
    end

    // Reset mid-message after the second of four bytes.
    do_reset();
    drive(4'b0010, 4'b0000, 32'h00006100, 1'b1);
    drive(4'b0010, 4'b0000, 32'h00006100, 1'b1);
    chk("rst_byte0", {valid, data, grant}, {1'b1, 8'h61, 2'd1});
    drive(4'b0010, 4'b0000, 32'h00006200, 1'b1);
    chk("rst_byte1", {valid, data, grant}, {1'b1, 8'h62, 2'd1});
    rst_n = 1'b0;
    drive(4'b0010, 4'b0000, 32'h00006300, 1'b1);
    rst_n = 1'b1;
    chk("rst_mid_msg", {valid, busy, grant, req_ready}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
